// File: rtl/cdc_edge_det_multi.sv
// rtl/cdc_edge_det_multi.sv - multi-channel synchronizer, debounce filter and edge/event detector
// Optional debounce filter enabled by defining CDC_EDGE_DET_FILT_EN.
module cdc_edge_det_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     async_in,
    input  logic [2*CH-1:0]   edge_sel,
    input  logic [CH-1:0]     evt_clr,
    output logic [CH-1:0]     level_out,
    output logic [CH-1:0]     pulse_out,
    output logic [CH-1:0]     evt_sticky,
    output logic [CH-1:0]     ovf,
    output logic              evt_any
);

    if (CH < 1 || CH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        FILT_CYC < 1 || FILT_CYC > 255) begin : g_bad_param
        $error("cdc_edge_det_multi: parameter out of range");
    end

    logic [CH-1:0] r_sync [SYNC_STAGES];
    logic [CH-1:0] w_sync;
    logic [CH-1:0] w_lvl_nxt;
    logic [CH-1:0] w_pulse;
    logic [CH-1:0] w_sticky_nxt;
    logic [CH-1:0] w_ovf_nxt;
    logic [CH-1:0] r_level;
    logic [CH-1:0] r_pulse;
    logic [CH-1:0] r_sticky;
    logic [CH-1:0] r_ovf;
    logic          r_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef CDC_EDGE_DET_FILT_EN
    localparam int CW = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

    logic [CW-1:0] r_cnt     [CH];
    logic [CW-1:0] w_cnt_nxt [CH];

    // Level flips only after FILT_CYC consecutive mismatching cycles; any match restarts the count.
    always_comb begin
        w_lvl_nxt = r_level;
        for (int i = 0; i < CH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_sync[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_lvl_nxt[i] = ~r_level[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) r_cnt[i] <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    assign w_lvl_nxt = w_sync;
`endif

    always_comb begin
        w_pulse = '0;
        for (int i = 0; i < CH; i++) begin
            w_pulse[i] = (w_lvl_nxt[i] & ~r_level[i] & edge_sel[2*i]) |
                         (~w_lvl_nxt[i] & r_level[i] & edge_sel[2*i+1]);
        end
    end

    // A pulse in the same cycle as a clear wins: sticky sets and ovf stays clear.
    assign w_sticky_nxt = r_pulse | (r_sticky & ~evt_clr);
    assign w_ovf_nxt    = (r_pulse & r_sticky & ~evt_clr) | (r_ovf & ~evt_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level  <= '0;
            r_pulse  <= '0;
            r_sticky <= '0;
            r_ovf    <= '0;
            r_any    <= 1'b0;
        end else begin
            r_level  <= w_lvl_nxt;
            r_pulse  <= w_pulse;
            r_sticky <= w_sticky_nxt;
            r_ovf    <= w_ovf_nxt;
            r_any    <= |w_sticky_nxt;
        end
    end

    assign level_out  = r_level;
    assign pulse_out  = r_pulse;
    assign evt_sticky = r_sticky;
    assign ovf        = r_ovf;
    assign evt_any    = r_any;

endmodule

// File: tb/tb_cdc_edge_det_multi.sv
// tb/tb_cdc_edge_det_multi.sv - directed self-checking bench for cdc_edge_det_multi
module tb_cdc_edge_det_multi;

`ifdef CDC_EDGE_DET_FILT_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_in;
    logic [7:0] edge_sel;
    logic [3:0] evt_clr;
    logic [3:0] level_out;
    logic [3:0] pulse_out;
    logic [3:0] evt_sticky;
    logic [3:0] ovf;
    logic       evt_any;

    int checks = 0;
    int errors = 0;

    cdc_edge_det_multi #(.CH(4), .SYNC_STAGES(2), .FILT_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .async_in   (async_in),
        .edge_sel   (edge_sel),
        .evt_clr    (evt_clr),
        .level_out  (level_out),
        .pulse_out  (pulse_out),
        .evt_sticky (evt_sticky),
        .ovf        (ovf),
        .evt_any    (evt_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic seen;

    initial begin
        rst      = 1'b1;
        async_in = '0;
        edge_sel = {2'b11, 2'b11, 2'b01, 2'b01};
        evt_clr  = '0;
        tick();
        tick();
        check("rst_level",  32'(level_out),  0);
        check("rst_pulse",  32'(pulse_out),  0);
        check("rst_sticky", 32'(evt_sticky), 0);
        check("rst_ovf",    32'(ovf),        0);
        check("rst_any",    32'(evt_any),    0);
        rst = 1'b0;
        tick();

        // ch0 rising edge
        async_in[0] = 1'b1;
        repeat (LAT-1) tick();
        check("c0_early_level", 32'(level_out[0]), 0);
        check("c0_early_pulse", 32'(pulse_out[0]), 0);
        tick();
        check("c0_level", 32'(level_out[0]), 1);
        check("c0_pulse", 32'(pulse_out[0]), 1);
        tick();
        check("c0_pulse_end", 32'(pulse_out[0]),  0);
        check("c0_sticky",    32'(evt_sticky[0]), 1);
        check("c0_any",       32'(evt_any),       1);

`ifdef CDC_EDGE_DET_FILT_EN
        // ch1 3-cycle glitch must be filtered out
        async_in[1] = 1'b1;
        repeat (3) tick();
        async_in[1] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen = seen | level_out[1] | pulse_out[1] | evt_sticky[1];
        end
        check("c1_glitch", 32'(seen), 0);
`else
        // ch1 1-cycle high passes straight through the synchronizer
        async_in[1] = 1'b1;
        tick();
        async_in[1] = 1'b0;
        repeat (2) tick();
        check("c1_nf_pulse", 32'(pulse_out[1]), 1);
        check("c1_nf_level", 32'(level_out[1]), 1);
        tick();
        check("c1_nf_pulse_end", 32'(pulse_out[1]), 0);
        check("c1_nf_level_end", 32'(level_out[1]), 0);
`endif

        // ch2 both-edge mode, second edge overflows
        async_in[2] = 1'b1;
        repeat (LAT) tick();
        check("c2_rise_pulse", 32'(pulse_out[2]), 1);
        repeat (10-LAT) tick();
        async_in[2] = 1'b0;
        repeat (LAT) tick();
        check("c2_fall_pulse", 32'(pulse_out[2]), 1);
        check("c2_fall_level", 32'(level_out[2]), 0);
        tick();
        check("c2_ovf",    32'(ovf[2]),        1);
        check("c2_sticky", 32'(evt_sticky[2]), 1);
        evt_clr = 4'b0100;
        tick();
        evt_clr = '0;
        check("c2_clr_sticky", 32'(evt_sticky[2]), 0);
        check("c2_clr_ovf",    32'(ovf[2]),        0);

        // ch3 clear coincident with a pulse: set wins
        async_in[3] = 1'b1;
        repeat (LAT) tick();
        check("c3_rise_pulse", 32'(pulse_out[3]), 1);
        tick();
        check("c3_sticky", 32'(evt_sticky[3]), 1);
        async_in[3] = 1'b0;
        repeat (LAT) tick();
        check("c3_fall_pulse", 32'(pulse_out[3]), 1);
        evt_clr = 4'b1000;
        tick();
        evt_clr = '0;
        check("c3_setwin_sticky", 32'(evt_sticky[3]), 1);
        check("c3_setwin_ovf",    32'(ovf[3]),        0);

        // ch1 mode none: level tracks, no events
        evt_clr = 4'hF;
        tick();
        evt_clr = '0;
        check("clr_all_any", 32'(evt_any), 0);
        edge_sel[3:2] = 2'b00;
        async_in[1] = 1'b1;
        repeat (LAT) tick();
        check("c1_none_level", 32'(level_out[1]), 1);
        check("c1_none_pulse", 32'(pulse_out[1]), 0);
        tick();
        check("c1_none_sticky", 32'(evt_sticky[1]), 0);
        check("c1_none_any",    32'(evt_any),       0);

        // reset in the middle of a ch0 debounce
        async_in[0] = 1'b0;
        repeat (LAT+1) tick();
        check("c0_low", 32'(level_out[0]), 0);
        async_in[0] = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_level",  32'(level_out),  0);
        check("mid_rst_pulse",  32'(pulse_out),  0);
        check("mid_rst_sticky", 32'(evt_sticky), 0);
        check("mid_rst_any",    32'(evt_any),    0);
        repeat (LAT-1) tick();
        check("post_rst_early", 32'(pulse_out[0]), 0);
        tick();
        check("post_rst_pulse", 32'(pulse_out), 32'h1);
        check("post_rst_level", 32'(level_out), 32'h3);
        tick();
        check("post_rst_sticky", 32'(evt_sticky), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_edge_det_multi.md
CDC_EDGE_DET_MULTI -- requirements
Module: cdc_edge_det_multi

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent channels, legal 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth per channel, legal 2..4.
REQ-003 SHALL have parameter FILT_CYC, default 4: debounce stability window in clk cycles, legal 1..255.
REQ-004 SHALL have a single clock and a synchronous active-high reset, named as follows: clk and rst.
REQ-005 SHALL provide port clk, input, 1: sole clock; all flops on its rising edge.
REQ-006 SHALL provide port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL provide port async_in, input, CH: asynchronous level inputs.
REQ-008 SHALL provide port edge_sel, input, 2*CH: per-channel mode {2i+1:2i}. 00=none, 01=rise, 10=fall, 11=both.
REQ-009 SHALL provide port evt_clr, input, CH: per-channel clear for evt_sticky and ovf.
REQ-010 SHALL provide port level_out, output, CH: synchronized, filtered level.
REQ-011 SHALL provide port pulse_out, output, CH: one-cycle pulse per qualified edge.
REQ-012 SHALL provide port evt_sticky, output, CH: latched qualified-edge flag.
REQ-013 SHALL provide port ovf, output, CH: second qualified edge seen while evt_sticky already set.
REQ-014 SHALL provide port evt_any, output, 1: OR-reduction of evt_sticky, registered.

Function
REQ-015 SHALL pass each async_in bit through a SYNC_STAGES-deep flop chain; the final stage is sync[i].
REQ-016 SHALL keep a per-channel counter of width clog2(FILT_CYC+1): cleared when sync[i]==level_out[i]; incremented when they differ.
REQ-017 SHALL toggle level_out[i] and clear the counter on the cycle a mismatch is present with counter==FILT_CYC-1. Latency from sync[i] change to level_out[i] change is exactly FILT_CYC cycles.
REQ-018 SHALL discard any sync[i] excursion shorter than FILT_CYC cycles; the counter restarts from 0 on the next mismatch.
REQ-019 SHALL register pulse_out[i] high for exactly one cycle, in the same cycle level_out[i] takes its new value, when that transition matches edge_sel[i]. edge_sel SHALL be sampled on the cycle the transition is computed.
REQ-020 SHALL make the total latency from a setup-meeting async_in change to level_out/pulse_out equal to SYNC_STAGES+FILT_CYC cycles.
REQ-021 SHALL set evt_sticky[i] the cycle after pulse_out[i]. It holds until evt_clr[i].
REQ-022 SHALL let set win on a simultaneous qualified edge and evt_clr[i]: evt_sticky stays 1 and ovf is not set.
REQ-023 SHALL set ovf[i] when a qualified edge occurs while evt_sticky[i]=1 and evt_clr[i]=0. It is cleared only by evt_clr[i] or rst.
REQ-024 SHALL keep channels fully independent; no cross-channel interaction except evt_any.
REQ-025 SHALL treat edge_sel=00 as follows: level_out still tracks; no pulse, sticky or ovf activity.

Reset
REQ-026 SHALL on rst=1 at a clk edge clear all sync flops, counters, level_out, pulse_out, evt_sticky, ovf and evt_any to 0 on that edge.
REQ-027 SHALL let rst mid-count abandon any in-progress debounce.
REQ-028 SHALL treat an async_in held high through reset release as a rising edge after SYNC_STAGES+FILT_CYC cycles.

Configuration
REQ-029 SHALL implement the debounce filter (REQ-016..018) only when macro CDC_EDGE_DET_FILT_EN is defined.
REQ-030 SHALL, when CDC_EDGE_DET_FILT_EN is undefined, omit the counters and FILT_CYC is ignored. level_out[i] is sync[i] delayed one flop, and latency is SYNC_STAGES+1. All other behaviour is unchanged.

Verification (CH=4, SYNC_STAGES=2, FILT_CYC=4, filter enabled unless stated)
REQ-031 SHALL cover: edge_sel[1:0]=01, async_in[0] rises before edge 10 -> level_out[0]=1 and pulse_out[0]=1 for one cycle at edge 16; evt_sticky[0]=1 and evt_any=1 at edge 17.
REQ-032 SHALL cover: async_in[1] high for 3 cycles then low -> level_out[1], pulse_out[1] and evt_sticky[1] stay 0.
REQ-033 SHALL cover: edge_sel[5:4]=11, async_in[2] rises then falls 10 cycles later, no clear -> two pulses; ovf[2]=1 after the second; evt_clr[2] -> both flags 0.
REQ-034 SHALL cover: evt_clr[3]=1 in the same cycle as pulse_out[3] with sticky already 1 -> evt_sticky[3] stays 1 and ovf[3] stays 0.
REQ-035 SHALL cover: rst pulsed 2 cycles into a debounce with async_in[0] held 1 -> all outputs 0 after that edge; pulse_out[0] exactly 6 cycles after rst deasserts.
REQ-036 SHALL cover, with CDC_EDGE_DET_FILT_EN undefined: a 1-cycle high on async_in[0] with rise mode -> one pulse 3 cycles later.
